// File: rtl/counter_4bit_up.sv
// Click-counter core: wrapping up-counter with enable, terminal-count and sticky overflow.
// Every rising clk edge (button release) with enable high advances the count.
module counter_4bit_up #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;

    // Out-of-range values (above MAX_V) are treated like the terminal value and wrap to 0.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (enable) begin
            if (count_q >= MAX_V) begin
                count_d    = '0;
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + ONE_V;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign tc       = (count_q == MAX_V) && enable;

endmodule

// File: tb/tb_counter_4bit_up.sv
// Bench for counter_4bit_up: default (wrap at 15) and MAX_COUNT=9 instances share stimulus
// and are compared against an arithmetic modulo model plus hand-computed literal checks.
module tb_counter_4bit_up;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] count_a;
    logic       tc_a;
    logic       overflow_a;
    logic [3:0] count_b;
    logic       tc_b;
    logic       overflow_b;

    int vectors;
    int miscompares;

    // Behavioural model: count advances modulo (MAX+1); overflow latches on any wrap.
    int mdl_cnt_a;
    int mdl_ov_a;
    int mdl_cnt_b;
    int mdl_ov_b;
    localparam int MAX_A = 15;
    localparam int MAX_B = 9;

    counter_4bit_up #(.WIDTH(4), .MAX_COUNT(MAX_A)) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .count(count_a), .tc(tc_a), .overflow(overflow_a)
    );

    counter_4bit_up #(.WIDTH(4), .MAX_COUNT(MAX_B)) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .count(count_b), .tc(tc_b), .overflow(overflow_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("count_a", int'(count_a), mdl_cnt_a);
        chk("overflow_a", int'(overflow_a), mdl_ov_a);
        chk("tc_a", int'(tc_a), int'((mdl_cnt_a == MAX_A) && enable));
        chk("count_b", int'(count_b), mdl_cnt_b);
        chk("overflow_b", int'(overflow_b), mdl_ov_b);
        chk("tc_b", int'(tc_b), int'((mdl_cnt_b == MAX_B) && enable));
    endtask

    task automatic model_edge();
        if (reset && enable) begin
            if (mdl_cnt_a == MAX_A) mdl_ov_a = 1;
            mdl_cnt_a = (mdl_cnt_a + 1) % (MAX_A + 1);
            if (mdl_cnt_b == MAX_B) mdl_ov_b = 1;
            mdl_cnt_b = (mdl_cnt_b + 1) % (MAX_B + 1);
        end
    endtask

    task automatic model_reset();
        mdl_cnt_a = 0;
        mdl_ov_a  = 0;
        mdl_cnt_b = 0;
        mdl_ov_b  = 0;
    endtask

    // One click: press (low 1 ns), release, then settle with clk high.
    task automatic click();
        clk = 1'b0;
        #1;
        model_edge();
        clk = 1'b1;
        #4;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b1;
        reset       = 1'b0;
        enable      = 1'b0;
        model_reset();
        #3;
        compare_all();
        chk("reset_count_lit", int'(count_a), 0);
        chk("reset_ovf_lit", int'(overflow_a), 0);
        chk("reset_tc_lit", int'(tc_a), 0);
        reset = 1'b1;
        #2;

        // Enable gating
        repeat (3) click();
        chk("gated_count_lit", int'(count_a), 0);
        enable = 1'b1;
        #1;
        click();
        chk("en_click1_lit", int'(count_a), 1);
        click();
        chk("en_click2_lit", int'(count_a), 2);

        // Press held low must not count; release counts once
        clk = 1'b0;
        #100;
        compare_all();
        chk("press_hold_lit", int'(count_a), 2);
        model_edge();
        clk = 1'b1;
        #2;
        compare_all();
        chk("release_lit", int'(count_a), 3);
        #2;

        // Asynchronous reset from 9, mid high phase, then clicks while held
        repeat (6) click();
        chk("pre_reset9_lit", int'(count_a), 9);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_clr_lit", int'(count_a), 0);
        chk("async_ovf_lit", int'(overflow_a), 0);
        repeat (3) click();
        chk("held_reset_lit", int'(count_a), 0);
        reset = 1'b1;
        #2;

        // Wrap-around at 15
        repeat (15) click();
        chk("wrap15_count_lit", int'(count_a), 15);
        chk("wrap15_tc_lit", int'(tc_a), 1);
        chk("wrap15_ovf_lit", int'(overflow_a), 0);
        click();
        chk("wrap0_count_lit", int'(count_a), 0);
        chk("wrap0_tc_lit", int'(tc_a), 0);
        chk("wrap0_ovf_lit", int'(overflow_a), 1);
        repeat (20) click();
        chk("ovf_sticky_lit", int'(overflow_a), 1);

        // MAX_COUNT = 9 instance: 1..9 then 0, overflow on 10th click
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            click();
            chk("mod10_count_lit", int'(count_b), (i == 10) ? 0 : i);
            chk("mod10_ovf_lit", int'(overflow_b), (i == 10) ? 1 : 0);
        end

        // Reset mid-count then resume
        do_reset();
        repeat (5) click();
        chk("mid5_lit", int'(count_a), 5);
        reset = 1'b0;
        #1;
        model_reset();
        #2;
        reset = 1'b1;
        #1;
        compare_all();
        click();
        chk("resume_lit", int'(count_a), 1);

        // Randomized enable and occasional reset pulses
        for (int n = 0; n < 400; n++) begin
            enable = 1'($urandom_range(0, 3) != 0);
            #1;
            compare_all();
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                compare_all();
                reset = 1'b1;
                #1;
            end
            click();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_4bit_up.md
# counter_4bit_up

Synchronous 4-bit up-counter with enable and an asynchronous active-low reset. It is the counting core behind the push-button click counter. The button line drives the clock, idling high; a press pulls it low and the release returns it high. The block produces a binary count that wraps modulo 16, plus terminal-count and sticky-overflow flags for downstream display or interrupt logic.

## Interface

Parameters:
- `WIDTH`, default 4: counter width in bits. The port `count` is `WIDTH` bits.
- `MAX_COUNT`, default 15 (2^WIDTH − 1): terminal value. After it the count wraps to 0. Legal range is 1 to 2^WIDTH − 1.

Ports, in positional order:
- `clk`, input, 1 bit: the single clock. All state updates on its rising edge, which in the click application is button release.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `enable`, input, 1 bit: count enable, active-high, sampled on the `clk` rising edge.
- `count`, output, `WIDTH` bits: current count, registered.
- `tc`, output, 1 bit: terminal count. It is combinational from the `count` register and equals (`count` == `MAX_COUNT`) && `enable`.
- `overflow`, output, 1 bit: sticky wrap flag, registered.

`tc` and `overflow` follow `count` positionally. Four-port positional instantiations leave them unconnected, which is legal.

## Operation

- `reset` low, at any time and regardless of `clk`:
  - `count` goes to 0 immediately.
  - `overflow` goes to 0.
  - `tc` follows from `count` = 0, so it is 0 unless `MAX_COUNT` = 0, which is illegal.
- While `reset` stays low, rising `clk` edges have no effect.
- On a rising `clk` edge with `reset` high:
  - `enable` = 0: `count` and `overflow` hold.
  - `enable` = 1 and `count` < `MAX_COUNT`: `count` becomes `count` + 1.
  - `enable` = 1 and `count` == `MAX_COUNT`: `count` becomes 0 and `overflow` becomes 1.
- Once set, `overflow` stays 1 until the next reset assertion.
- Arithmetic is unsigned, `WIDTH` bits, with no saturation.
- If `count` holds a value above `MAX_COUNT`, which is unreachable in normal use, the next enabled edge loads 0 and sets `overflow`.
- The block does no debouncing. Every rising edge on `clk` counts. Debounce, if required, lives upstream.
- Falling `clk` edges (button press) have no effect.

## Timing

- Latency: `count` updates on the same rising edge that samples `enable` = 1. The new value is visible after clock-to-q, with no extra pipeline stage.
- Reset:
  - Assertion is asynchronous. Outputs clear within propagation delay, with no clock needed.
  - Deassertion is released to the first rising `clk` edge that occurs while `reset` is high.
  - A rising edge coincident with reset deassertion must not increment. The integrating design synchronises deassertion to `clk`, or sequences `reset` and `clk` so that they do not coincide.
- `enable` must be stable around each rising `clk` edge. Its setup and hold are measured against that edge.
- `tc` is a combinational output from registered `count` and the `enable` input.
- `count` and `overflow` are glitch-free registered outputs.

## Test plan

- **Asynchronous reset:**
  - Stimulus: from any count, e.g. 9, drive `reset` low midway between `clk` edges.
  - Required response: `count` = 0 and `overflow` = 0 immediately.
  - Then hold `reset` low for 3 clicks. Required response: `count` stays 0.
- **Enable gating:**
  - Stimulus: `reset` high, `enable` = 0, 3 clicks (low for 1 ns, then high).
  - Required response: `count` = 0.
  - Then set `enable` = 1 and apply 2 clicks. Required response: `count` = 2, changing on each release, i.e. each rising edge.
- **Press versus release:**
  - Stimulus: with `enable` = 1, drive `clk` low and hold it low for 100 ns.
  - Required response: `count` unchanged.
  - Then drive `clk` high. Required response: `count` increments by exactly 1.
- **Wrap-around:**
  - Stimulus: 15 enabled clicks from 0.
  - Required response: `count` = 15, `tc` = 1, `overflow` = 0.
  - Then one more click. Required response: `count` = 0, `tc` = 0, `overflow` = 1.
  - Then 20 further clicks. Required response: `overflow` remains 1.
- **Non-default terminal value:**
  - Stimulus: `MAX_COUNT` = 9, 10 enabled clicks from 0.
  - Required response: the sequence runs 1 through 9, then 0. `overflow` rises on the 10th click.
- **Reset mid-count then resume:**
  - Stimulus: at `count` = 5, pulse `reset` low for 3 ns, then release it with `enable` = 1 and apply 1 click.
  - Required response: `count` = 1.
